tm1640_display_ctrl: RTL and testbench

//  Frame scheduler for TM1640_driver. Holds a 16-byte shadow display buffer and brightness/on state.

---
 rtl/tm1640_display_ctrl_if.sv | 30 +++
 rtl/tm1640_display_ctrl.sv | 171 +++++++++++++++++
 tb/tb_tm1640_display_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/tm1640_display_ctrl_if.sv
// Host/driver-side signal bundle for tm1640_display_ctrl.
// The master side is the host plus driver; the slave side is the frame scheduler.
interface tm1640_display_ctrl_if;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
    logic       bright_we;
    logic [2:0] bright;
    logic       disp_on;
    logic       busy;
    logic       ack_err;
    logic       drv_tvalid;
    logic [7:0] drv_tdata;
    logic [7:0] drv_sendBytes;
    logic [7:0] drv_cmd1;
    logic [7:0] drv_cmd2;
    logic [7:0] drv_cmd3;
    logic       drv_done;

    modport master (
        output wr_en, wr_addr, wr_data, commit, bright_we, bright, disp_on, drv_done,
        input  busy, ack_err, drv_tvalid, drv_tdata, drv_sendBytes, drv_cmd1, drv_cmd2, drv_cmd3
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, bright_we, bright, disp_on, drv_done,
        output busy, ack_err, drv_tvalid, drv_tdata, drv_sendBytes, drv_cmd1, drv_cmd2, drv_cmd3
    );
endinterface

// File: rtl/tm1640_display_ctrl.sv
// Frame scheduler for the TM1640 driver: shadow/active display buffers, request
// arbitration, and the cmd1/cmd2/16-byte/cmd3 stream with done handshake.
module tm1640_display_ctrl #(
    parameter int unsigned REFRESH_CYCLES = 1_000_000,
    parameter int unsigned ACK_TIMEOUT    = 8,
    parameter logic [2:0]  DEF_BRIGHT     = 3'd7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tm1640_display_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_ACK, S_DONE, S_GAP} state_t;

    localparam logic [31:0] REF_LAST = 32'(REFRESH_CYCLES - 1);
    localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [15:0] r_cnt, w_cnt_next;
    logic [7:0]  r_shadow [16];
    logic [7:0]  r_active [16];
    logic [2:0]  r_bright, r_bright_act;
    logic        r_disp_on, r_disp_on_act;
    logic        r_pend_commit, r_pend_bright, r_pend_refresh;
    logic [31:0] r_refresh_cnt;
    logic        r_ack_err;
    logic        w_refresh_hit, w_req, w_set_err;

    assign w_refresh_hit = (REFRESH_CYCLES != 0) && (r_refresh_cnt == REF_LAST);
    // Raw events join the flags so a request in an idle cycle reaches LOAD next cycle.
    assign w_req = r_pend_commit | r_pend_bright | r_pend_refresh
                 | bus.commit | bus.bright_we | w_refresh_hit;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_set_err  = 1'b0;
        unique case (r_state)
            S_IDLE: if (bus.drv_done && w_req) w_next = S_LOAD;
            S_LOAD: begin
                w_next     = S_STREAM;
                w_cnt_next = '0;
            end
            S_STREAM: begin
                if (r_cnt == 16'd15) begin
                    w_next     = S_ACK;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            S_ACK: begin
                if (!bus.drv_done) begin
                    w_next     = S_DONE;
                    w_cnt_next = '0;
                end else if (r_cnt >= ACK_LAST) begin
                    w_next     = S_GAP;
                    w_cnt_next = '0;
                    w_set_err  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            S_DONE: begin
                if (bus.drv_done) begin
                    w_next     = S_GAP;
                    w_cnt_next = '0;
                end
            end
            S_GAP: begin
                if (r_cnt == 16'd1) begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy          = (r_state != S_IDLE);
        bus.ack_err       = r_ack_err;
        bus.drv_tvalid    = (r_state == S_STREAM);
        bus.drv_tdata     = (r_state == S_STREAM) ? r_active[r_cnt[3:0]] : '0;
        bus.drv_sendBytes = 8'd16;
        bus.drv_cmd1      = 8'h40;
        bus.drv_cmd2      = 8'hC0;
        bus.drv_cmd3      = {4'b1000, r_disp_on_act, r_bright_act};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
        end else if (REFRESH_CYCLES == 0 || w_refresh_hit) begin
            r_refresh_cnt <= '0;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 32'd1;
        end
    end

    // Set wins over the LOAD clear so a request landing on LOAD still gets a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_commit  <= 1'b0;
            r_pend_bright  <= 1'b0;
            r_pend_refresh <= 1'b0;
        end else if (r_state == S_LOAD) begin
            r_pend_commit  <= bus.commit;
            r_pend_bright  <= bus.bright_we;
            r_pend_refresh <= w_refresh_hit;
        end else begin
            r_pend_commit  <= r_pend_commit  | bus.commit;
            r_pend_bright  <= r_pend_bright  | bus.bright_we;
            r_pend_refresh <= r_pend_refresh | w_refresh_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bright  <= DEF_BRIGHT;
            r_disp_on <= 1'b1;
        end else if (bus.bright_we) begin
            r_bright  <= bus.bright;
            r_disp_on <= bus.disp_on;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) r_shadow[i] <= '0;
        end else if (bus.wr_en) begin
            r_shadow[bus.wr_addr] <= bus.wr_data;
        end
    end

    // A shadow write landing in the LOAD cycle is forwarded into the active copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) r_active[i] <= '0;
            r_bright_act  <= DEF_BRIGHT;
            r_disp_on_act <= 1'b1;
        end else if (r_state == S_LOAD) begin
            for (int unsigned i = 0; i < 16; i++) begin
                r_active[i] <= (bus.wr_en && (bus.wr_addr == 4'(i))) ? bus.wr_data : r_shadow[i];
            end
            r_bright_act  <= r_bright;
            r_disp_on_act <= r_disp_on;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_err <= 1'b0;
        end else if (w_set_err) begin
            r_ack_err <= 1'b1;
        end else if (bus.commit) begin
            r_ack_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tm1640_display_ctrl.sv
// Directed bench: dut_a (refresh off) with an acking driver model, dut_b (refresh 100)
// with drv_done tied high for refresh period and mid-frame reset checks.
module tb_tm1640_display_ctrl;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tm1640_display_ctrl_if ifa ();
    tm1640_display_ctrl_if ifb ();

    tm1640_display_ctrl #(.REFRESH_CYCLES(0), .ACK_TIMEOUT(8), .DEF_BRIGHT(3'd7)) dut_a (
        .clk(clk), .rst_n(rst_a), .bus(ifa.slave));
    tm1640_display_ctrl #(.REFRESH_CYCLES(100), .ACK_TIMEOUT(8), .DEF_BRIGHT(3'd7)) dut_b (
        .clk(clk), .rst_n(rst_b), .bus(ifb.slave));

    // Driver model for dut_a: drops done for 6 cycles once the stream ends.
    logic ack_en = 1'b1;
    logic a_tv_q = 1'b0;
    int   a_busy_cnt = 0;
    always @(posedge clk) begin
        if (a_tv_q && !ifa.drv_tvalid && ack_en) a_busy_cnt <= 6;
        else if (a_busy_cnt != 0)                a_busy_cnt <= a_busy_cnt - 1;
        a_tv_q <= ifa.drv_tvalid;
    end
    assign ifa.drv_done = (a_busy_cnt == 0);

    int         a_frames = 0;
    int         a_run = 0;
    logic [7:0] a_buf [16];
    logic [7:0] a_cmd3 = '0;
    logic       a_prev = 1'b0;
    always @(negedge clk) begin
        if (ifa.drv_tvalid) begin
            if (!a_prev) begin
                a_frames++;
                a_run  = 0;
                a_cmd3 = ifa.drv_cmd3;
            end
            if (a_run < 16) a_buf[a_run] = ifa.drv_tdata;
            a_run++;
        end
        a_prev = ifa.drv_tvalid;
    end

    int   b_rise[$];
    logic b_prev = 1'b0;
    always @(negedge clk) begin
        if (ifb.drv_tvalid && !b_prev) b_rise.push_back(cyc);
        b_prev = ifb.drv_tvalid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_quiet(input string tag);
        int q = 0;
        int n = 0;
        while (q < 5 && n < 1000) begin
            @(negedge clk);
            n++;
            if (ifa.busy) q = 0; else q++;
        end
        chk(tag, (q >= 5), 1);
    endtask

    task automatic wait_tvalid_a(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifa.drv_tvalid && n < 200);
        chk(tag, ifa.drv_tvalid, 1);
    endtask

    task automatic pulse_commit();
        @(posedge clk); #1 ifa.commit = 1'b1;
        @(posedge clk); #1 ifa.commit = 1'b0;
    endtask

    task automatic write_a(input logic [3:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        ifa.wr_en = 1'b1; ifa.wr_addr = addr; ifa.wr_data = data;
        @(posedge clk); #1 ifa.wr_en = 1'b0;
    endtask

    int f0;
    int n;

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        ifa.wr_en = 0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.commit = 0;
        ifa.bright_we = 0; ifa.bright = '0; ifa.disp_on = 0;
        ifb.wr_en = 0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.commit = 0;
        ifb.bright_we = 0; ifb.bright = '0; ifb.disp_on = 0; ifb.drv_done = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);

        chk("rst_busy",    ifa.busy, 0);
        chk("rst_ack_err", ifa.ack_err, 0);
        chk("rst_tvalid",  ifa.drv_tvalid, 0);
        chk("rst_tdata",   ifa.drv_tdata, 8'h00);
        chk("rst_cmd3",    ifa.drv_cmd3, 8'h8F);
        chk("sendBytes",   ifa.drv_sendBytes, 8'd16);
        chk("cmd1",        ifa.drv_cmd1, 8'h40);
        chk("cmd2",        ifa.drv_cmd2, 8'hC0);

        // 1: full buffer 0x00..0x0F, commit, check latency and one frame
        for (int i = 0; i < 16; i++) write_a(4'(i), 8'(i));
        f0 = a_frames;
        @(posedge clk); #1 ifa.commit = 1'b1;
        @(posedge clk); #1 ifa.commit = 1'b0;
        @(negedge clk);
        chk("t1_load_busy",   ifa.busy, 1);
        chk("t1_load_tvalid", ifa.drv_tvalid, 0);
        @(negedge clk);
        chk("t1_first_tvalid", ifa.drv_tvalid, 1);
        chk("t1_first_tdata",  ifa.drv_tdata, 8'h00);
        wait_quiet("t1_quiet");
        chk("t1_frames", a_frames - f0, 1);
        chk("t1_len",    a_run, 16);
        chk("t1_cmd3",   a_cmd3, 8'h8F);
        for (int i = 0; i < 16; i++) chk($sformatf("t1_data%0d", i), a_buf[i], 8'(i));
        chk("t1_drv_done_seen", ifa.ack_err, 0);

        // 2: brightness change alone triggers a frame
        f0 = a_frames;
        @(posedge clk); #1;
        ifa.bright_we = 1'b1; ifa.bright = 3'd3; ifa.disp_on = 1'b0;
        @(posedge clk); #1 ifa.bright_we = 1'b0;
        wait_quiet("t2_quiet");
        chk("t2_frames", a_frames - f0, 1);
        chk("t2_cmd3",   a_cmd3, 8'h83);
        chk("t2_data7",  a_buf[7], 8'h07);
        chk("t2_data15", a_buf[15], 8'h0F);

        // 3: several requests during STREAM collapse into one follow-on frame
        f0 = a_frames;
        pulse_commit();
        wait_tvalid_a("t3_stream");
        @(posedge clk); #1 ifa.commit = 1'b1;
        @(posedge clk); #1 ifa.commit = 1'b0;
        @(posedge clk); #1 ifa.commit = 1'b1;
        ifa.bright_we = 1'b1; ifa.bright = 3'd5; ifa.disp_on = 1'b1;
        @(posedge clk); #1 ifa.commit = 1'b0; ifa.bright_we = 1'b0;
        @(posedge clk); #1 ifa.commit = 1'b1;
        @(posedge clk); #1 ifa.commit = 1'b0;
        wait_quiet("t3_quiet");
        chk("t3_frames", a_frames - f0, 2);
        chk("t3_cmd3",   a_cmd3, 8'h8D);
        chk("t3_len",    a_run, 16);

        // 4: shadow write during STREAM only shows up in the next frame
        f0 = a_frames;
        pulse_commit();
        wait_tvalid_a("t4_stream");
        write_a(4'd5, 8'hAA);
        wait_quiet("t4_quiet1");
        chk("t4_old_byte", a_buf[5], 8'h05);
        chk("t4_frames1",  a_frames - f0, 1);
        pulse_commit();
        wait_quiet("t4_quiet2");
        chk("t4_new_byte", a_buf[5], 8'hAA);
        chk("t4_frames2",  a_frames - f0, 2);

        // commit + bright_we together, shadow write in the LOAD cycle is forwarded
        f0 = a_frames;
        @(posedge clk); #1;
        ifa.commit = 1'b1; ifa.bright_we = 1'b1; ifa.bright = 3'd1; ifa.disp_on = 1'b1;
        @(posedge clk); #1;
        ifa.commit = 1'b0; ifa.bright_we = 1'b0;
        ifa.wr_en = 1'b1; ifa.wr_addr = 4'd0; ifa.wr_data = 8'h55;
        @(posedge clk); #1 ifa.wr_en = 1'b0;
        wait_quiet("tb_quiet");
        chk("tb_frames",  a_frames - f0, 1);
        chk("tb_cmd3",    a_cmd3, 8'h89);
        chk("tb_wthru",   a_buf[0], 8'h55);
        chk("tb_data5",   a_buf[5], 8'hAA);

        // 5: driver never acks -> sticky ack_err, cleared by next commit
        ack_en = 1'b0;
        pulse_commit();
        wait_quiet("t5_quiet1");
        chk("t5_ack_err_set", ifa.ack_err, 1);
        ack_en = 1'b1;
        @(posedge clk); #1 ifa.commit = 1'b1;
        @(posedge clk); #1 ifa.commit = 1'b0;
        @(negedge clk);
        chk("t5_ack_err_clr", ifa.ack_err, 0);
        wait_quiet("t5_quiet2");
        chk("t5_ack_err_stay", ifa.ack_err, 0);

        // 6: refresh period on dut_b, then async reset mid-STREAM
        n = 0;
        while (b_rise.size() < 3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t6_rises", (b_rise.size() >= 3), 1);
        if (b_rise.size() >= 3) begin
            chk("t6_period1", b_rise[1] - b_rise[0], 100);
            chk("t6_period2", b_rise[2] - b_rise[1], 100);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifb.drv_tvalid && n < 200);
        chk("t6_stream", ifb.drv_tvalid, 1);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("t6_rst_tvalid", ifb.drv_tvalid, 0);
        chk("t6_rst_busy",   ifb.busy, 0);
        chk("t6_rst_tdata",  ifb.drv_tdata, 8'h00);
        @(posedge clk); #1 rst_b = 1'b1;
        @(negedge clk);
        chk("t6_after_busy", ifb.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
